// File: rtl/minterm_pkg.sv
// rtl/minterm_pkg.sv - shared types and defaults for the minterm unit
package minterm_pkg;

    localparam int N_DEFAULT = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/minterm_decoder.sv
// rtl/minterm_decoder.sv - combinational N-to-2**N one-hot minterm decoder
module minterm_decoder #(
    parameter int N = 2,
    localparam int M = 1 << N
) (
    input  logic [N-1:0] x,
    output logic [M-1:0] z
);

    assign z = M'(1) << x;

endmodule

// File: rtl/minterm_unit.sv
// rtl/minterm_unit.sv - loadable truth table with one-hot minterm decode and handshaked output
// Table is loaded serially (minterm 0 first); accepted x yields z=onehot(x), f=table[x] one cycle later.
module minterm_unit
    import minterm_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int M = 1 << N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] z,
    output logic         f
);

    localparam int CW = $clog2(M) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  table_q, table_d;
    logic          out_valid_q, out_valid_d;
    logic [M-1:0]  z_q, z_d;
    logic          f_q, f_d;
    logic [M-1:0]  onehot_x;
    logic          accept;

    minterm_decoder #(.N(N)) u_decoder (
        .x (x),
        .z (onehot_x)
    );

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign cfg_busy  = (state_q == LOAD);
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign f         = f_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        unique case (state_q)
            EMPTY, RUN: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                // A restart rewinds the counter but keeps bits already written.
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    table_d[cnt_q[CW-2:0]] = cfg_bit;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(M - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        f_d         = f_q;
        if (accept) begin
            out_valid_d = 1'b1;
            z_d         = onehot_x;
            f_d         = table_q[x];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            table_q     <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            f_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            table_q     <= table_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            f_q         <= f_d;
        end
    end

endmodule

// File: tb/tb_minterm_unit.sv
// tb/tb_minterm_unit.sv - directed self-checking bench for minterm_unit with N=2
module tb_minterm_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_busy;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] x = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] z;
    logic       f;

    int n_checks = 0;
    int n_errors = 0;

    minterm_unit #(.N(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .f         (f)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // tbl[k] is the table bit for minterm k
    task automatic load_table(input logic [3:0] tbl);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_bit = tbl[k];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_f", 32'(f), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // table 1,0,0,0
        load_table(4'b0001);
        check("t1_busy_done", 32'(cfg_busy), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        x = 2'd0; in_valid = 1'b1;
        tick();
        check("t1_x0_valid", 32'(out_valid), 32'd1);
        check("t1_x0_z", 32'(z), 32'h1);
        check("t1_x0_f", 32'(f), 32'd1);
        x = 2'd3;
        tick();
        in_valid = 1'b0;
        check("t1_x3_z", 32'(z), 32'h8);
        check("t1_x3_f", 32'(f), 32'd0);
        tick();
        check("t1_drain_valid", 32'(out_valid), 32'd0);
        check("t1_drain_z_hold", 32'(z), 32'h8);

        // AND table, full-throughput stream
        load_table(4'b1000);
        for (int i = 0; i < 4; i++) begin
            x = 2'(i); in_valid = 1'b1;
            check("and_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("and_valid", 32'(out_valid), 32'd1);
            check("and_f", 32'(f), (i == 3) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check("and_drained", 32'(out_valid), 32'd0);

        // backpressure for three cycles
        out_ready = 1'b0;
        x = 2'd2; in_valid = 1'b1;
        tick();
        x = 2'd1;
        for (int i = 0; i < 3; i++) begin
            check("bp_z_stable", 32'(z), 32'h4);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_z", 32'(z), 32'h2);
        check("bp_next_f", 32'(f), 32'd0);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // pending result survives cfg_start
        out_ready = 1'b0;
        x = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("pend_busy", 32'(cfg_busy), 32'd1);
        check("pend_in_ready", 32'(in_ready), 32'd0);
        check("pend_valid", 32'(out_valid), 32'd1);
        check("pend_z", 32'(z), 32'h8);
        check("pend_f", 32'(f), 32'd1);
        out_ready = 1'b1;
        tick();
        check("pend_drained", 32'(out_valid), 32'd0);
        check("pend_z_hold", 32'(z), 32'h8);

        // restart after three bits, then XOR; cfg_valid in cfg_start cycle ignored
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("restart_busy", 32'(cfg_busy), 32'd1);
        check("restart_in_ready", 32'(in_ready), 32'd0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_bit = (k == 1 || k == 2);
            tick();
        end
        cfg_valid = 1'b0;
        check("xor_busy", 32'(cfg_busy), 32'd0);
        check("xor_in_ready", 32'(in_ready), 32'd1);
        // cfg_valid in RUN is ignored
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("run_cfg_ignored", 32'(cfg_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            x = 2'(i); in_valid = 1'b1;
            tick();
            check("xor_z", 32'(z), 32'(4'b0001 << i));
            check("xor_f", 32'(f), (i == 1 || i == 2) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        tick();

        // reset mid-load with a result pending, asserted between edges
        out_ready = 1'b0;
        x = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst2_pre_valid", 32'(out_valid), 32'd1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst2_async_valid", 32'(out_valid), 32'd0);
        check("rst2_async_z", 32'(z), 32'd0);
        check("rst2_async_f", 32'(f), 32'd0);
        check("rst2_async_busy", 32'(cfg_busy), 32'd0);
        check("rst2_async_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        x = 2'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_in_ready", 32'(in_ready), 32'd0);
            check("empty_out_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        load_table(4'b0110);
        check("reload_ready", 32'(in_ready), 32'd1);
        x = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("reload_z", 32'(z), 32'h4);
        check("reload_f", 32'(f), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minterm_unit.md
MINTERM_UNIT -- requirements
Module: minterm_unit

Interface
REQ-001 Parameter N, default 2, number of boolean inputs; legal range 1..6.
REQ-002 Derived constant M = 2**N, number of minterms; not overridable.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_start  input  1  pulse; begins (re)loading the truth table.
REQ-006 cfg_valid  input  1  cfg_bit valid this cycle.
REQ-007 cfg_bit  input  1  next truth-table bit, minterm index 0 first.
REQ-008 cfg_busy  output  1  high while in LOAD state.
REQ-009 in_valid  input  1  x valid.
REQ-010 in_ready  output  1  unit accepts x this cycle.
REQ-011 x  input  N  input configuration, x[N-1] MSB.
REQ-012 out_valid  output  1  z/f valid.
REQ-013 out_ready  input  1  consumer accepts z/f.
REQ-014 z  output  M  one-hot minterm vector: z[k]=1 iff accepted x == k.
REQ-015 f  output  1  sum-of-products value: table[x] of accepted x.

Function
REQ-016 FSM states EMPTY (no table), LOAD, RUN; reset state EMPTY.
REQ-017 EMPTY/RUN + cfg_start -> LOAD, bit counter cleared to 0.
REQ-018 LOAD + cfg_start -> counter cleared to 0, table bits already written remain, stay LOAD.
REQ-019 LOAD + cfg_valid (no cfg_start) -> table[counter] <= cfg_bit, counter+1; on writing index M-1 -> RUN next cycle.
REQ-020 cfg_valid outside LOAD, or in the cycle of cfg_start, is ignored.
REQ-021 in_ready = (state == RUN) && (!out_valid || out_ready); combinational, never depends on in_valid.
REQ-022 Transfer on in_valid && in_ready: at that edge z <= onehot(x), f <= table[x], out_valid <= 1; latency exactly 1 cycle.
REQ-023 out_valid && out_ready && no new transfer -> out_valid <= 0; z, f hold last values.
REQ-024 out_valid && !out_ready -> z, f, out_valid held stable; no input accepted.
REQ-025 Simultaneous output drain and input accept -> new result loaded, out_valid stays 1 (full throughput, one result per cycle).
REQ-026 Pending output result survives cfg_start and drains normally during LOAD; f reflects table at accept time.
REQ-027 Counter width ceil(log2(M))+1; no wrap-around possible since LOAD exits at index M-1.

Reset
REQ-028 On reset: state EMPTY, counter 0, table all 0, out_valid 0, z all 0, f 0, in_ready 0, cfg_busy 0.
REQ-029 Reset asserted mid-load or with out_valid high discards all progress; the previous table is not retained.
REQ-030 Outputs reach reset values asynchronously on reset assertion, independent of clock.

Structure
REQ-031 Shared package minterm_pkg holds state enum (EMPTY, LOAD, RUN) and the default N.
REQ-032 One sub-module minterm_decoder (combinational, parameter N, x -> M-bit one-hot) instantiated for z.
REQ-033 Truth table is an M-bit register; f selection is a plain index into it.

Verification (N=2)
REQ-034 Reset, load 1,0,0,0 then x=0 -> out_valid next cycle, z=4'b0001, f=1; x=3 -> z=4'b1000, f=0.
REQ-035 Load 0,0,0,1 (AND); stream x=0,1,2,3 with out_ready=1 -> f=0,0,0,1 on four consecutive cycles, in_ready high throughout.
REQ-036 out_ready=0 for 3 cycles with out_valid=1, x=2 -> z=4'b0100 stable, in_ready=0; release -> next x accepted that cycle.
REQ-037 Reset after 2 of 4 cfg bits -> EMPTY, in_ready=0 indefinitely until a full 4-bit load completes.
REQ-038 Result pending with out_ready=0, then cfg_start -> cfg_busy=1, in_ready=0, pending result drains unchanged once out_ready=1.
REQ-039 cfg_start mid-load after 3 bits, then 4 new bits 0,1,1,0 (XOR) -> x=1 gives f=1, x=3 gives f=0.
